// File: rtl/calc_core_seq_if.sv
// Request/response bundle between operand-entry logic and calc_core_seq.
// The master issues start/operation/operands; the slave returns the held result and status.
interface calc_core_seq_if #(
  parameter int W = 16
);
  logic             start;
  logic [2:0]       operation;
  logic [W-1:0]     operand_a;
  logic [W-1:0]     operand_b;
  logic [2*W-1:0]   result;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, operation, operand_a, operand_b,
    input  result, busy, done, error
  );

  modport slave (
    input  start, operation, operand_a, operand_b,
    output result, busy, done, error
  );
endinterface

// File: rtl/calc_core_seq.sv
// Iterative unsigned calculator core: MUL, DIV (quotient+remainder), SQRT and BIN2BCD
// share one accumulator/aux register pair, one operation at a time, start/busy/done handshake.
module calc_core_seq #(
  parameter int W          = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic           clk,
  input  logic           rst,
  calc_core_seq_if.slave bus
);
  localparam int HW = W / 2;
  localparam int BW = 4 * BCD_DIGITS;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_e;
  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_DIV  = 3'd1,
    OP_SQRT = 3'd2,
    OP_BCD  = 3'd3
  } op_e;

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   aux_q, aux_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] result_q, result_d;
  logic           fault_q, fault_d;
  logic           error_q, error_d;
  logic           done_q, done_d;

  logic           req_ok;
  logic [CW-1:0]  last_iter;
  logic [W-1:0]   hi, lo;
  logic [2*W-1:0] step_acc, fin_result, acc_adj;
  logic [W-1:0]   step_aux;
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [W+1:0]   sq_rem_t, sq_trial;
  logic [W-1:0]   sq_sub;

  assign hi = acc_q[2*W-1:W];
  assign lo = acc_q[W-1:0];

  assign req_ok = (bus.operation <= 3'd3) &&
                  !((bus.operation == OP_DIV) && (bus.operand_b == '0));
  assign last_iter = (op_q == OP_SQRT) ? CW'(HW - 1) : CW'(W - 1);

  // One iteration of the selected algorithm. MUL/DIV/SQRT keep {hi,lo} in acc;
  // SQRT builds its root in aux, BIN2BCD shifts binary out of aux into BCD digits in acc.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    div_shift = {hi, lo[W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    sq_rem_t  = {hi, lo[W-1:W-2]};
    sq_trial  = {aux_q, 2'b01};
    sq_sub    = W'(sq_rem_t - sq_trial);
    acc_adj   = acc_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    step_acc = acc_q;
    step_aux = aux_q;
    case (op_q)
      OP_MUL:  step_acc = {mul_sum, lo[W-1:1]};
      OP_DIV:  step_acc = div_diff[W] ? {div_shift[W-1:0], lo[W-2:0], 1'b0}
                                      : {div_diff[W-1:0],  lo[W-2:0], 1'b1};
      OP_SQRT: begin
        if (sq_rem_t >= sq_trial) begin
          step_acc = {sq_sub, lo[W-3:0], 2'b00};
          step_aux = {aux_q[W-2:0], 1'b1};
        end else begin
          step_acc = {sq_rem_t[W-1:0], lo[W-3:0], 2'b00};
          step_aux = {aux_q[W-2:0], 1'b0};
        end
      end
      // The acc MSB is always zero for legal BCD_DIGITS; rotating it into aux keeps every bit live.
      OP_BCD:  {step_acc, step_aux} = {acc_adj[2*W-2:0], aux_q, acc_adj[2*W-1]};
      default: ;
    endcase
  end

  assign fin_result = (op_q == OP_SQRT) ? {hi, {HW{1'b0}}, aux_q[HW-1:0]} : acc_q;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    aux_d    = aux_q;
    acc_d    = acc_q;
    result_d = result_q;
    fault_d  = fault_q;
    error_d  = error_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          fault_d = !req_ok;
          cnt_d   = '0;
          if (req_ok) begin
            state_d = S_CALC;
            op_d    = op_e'(bus.operation);
            b_d     = bus.operand_b;
            if (bus.operation == OP_BCD) begin
              acc_d = '0;
              aux_d = bus.operand_a;
            end else begin
              acc_d = {{W{1'b0}}, bus.operand_a};
              aux_d = '0;
            end
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        aux_d = step_aux;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == last_iter) state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        error_d  = fault_q;
        result_d = fault_q ? '0 : fin_result;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      b_q      <= '0;
      aux_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      fault_q  <= 1'b0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      aux_q    <= aux_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      fault_q  <= fault_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.error  = error_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_calc_core_seq.sv
// Scoreboard bench for calc_core_seq: stimulus pushes expected {result, error, done cycle},
// an independent monitor pops and compares on every done pulse.
module tb_calc_core_seq;
  localparam int W  = 16;
  localparam int BD = 5;

  localparam logic [2:0] MUL  = 3'd0;
  localparam logic [2:0] DIV  = 3'd1;
  localparam logic [2:0] SQRT = 3'd2;
  localparam logic [2:0] BCD  = 3'd3;

  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
    int             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  calc_core_seq_if #(.W(W)) bus ();

  calc_core_seq #(.W(W), .BCD_DIGITS(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("result", 64'(bus.result), 64'(e.res));
          check("error", 64'(bus.error), 64'(e.err));
          check("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int k);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.operation = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
    k = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int busy_cnt);
    bit seen = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.busy === 1'b1) busy_cnt++;
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] res, input logic err,
                        input int lat);
    int k;
    int busy_cnt;
    issue(op, a, b, k);
    sb_q.push_back('{res: res, err: err, cyc: k + lat});
    wait_done(name, busy_cnt);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int k;
    int busy_cnt;
    int dones;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.operation = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_error", 64'(bus.error), 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    rst = 1'b0;

    // Directed vectors, expected values worked out by hand.
    run_op("mul_max",    MUL,  16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 17);
    run_op("div_1000_7", DIV,  16'd1000, 16'd7,    32'h0006_008E, 1'b0, 17);
    run_op("div_by_0",   DIV,  16'h1234, 16'h0000, 32'h0000_0000, 1'b1, 1);
    run_op("bad_opcode", 3'b111, 16'h0003, 16'h0004, 32'h0000_0000, 1'b1, 1);
    run_op("mul_3x4",    MUL,  16'd3,    16'd4,    32'h0000_000C, 1'b0, 17);
    // 65535 - 255*255 = 510 = 0x1FE
    run_op("sqrt_max",   SQRT, 16'hFFFF, 16'h0000, 32'h01FE_00FF, 1'b0, 9);
    run_op("bcd_max",    BCD,  16'hFFFF, 16'h0000, 32'h0006_5535, 1'b0, 17);
    run_op("sqrt_99",    SQRT, 16'd99,   16'hABCD, 32'h0012_0009, 1'b0, 9);
    run_op("sqrt_144",   SQRT, 16'd144,  16'h0000, 32'h0000_000C, 1'b0, 9);
    run_op("sqrt_0",     SQRT, 16'd0,    16'h0000, 32'h0000_0000, 1'b0, 9);
    run_op("div_small",  DIV,  16'd5,    16'd9,    32'h0005_0000, 1'b0, 17);
    run_op("div_by_1",   DIV,  16'hFFFF, 16'd1,    32'h0000_FFFF, 1'b0, 17);
    run_op("mul_zero",   MUL,  16'd0,    16'hFFFF, 32'h0000_0000, 1'b0, 17);
    run_op("mul_shift",  MUL,  16'h1234, 16'h0010, 32'h0001_2340, 1'b0, 17);
    run_op("bcd_1234",   BCD,  16'd1234, 16'hFFFF, 32'h0000_1234, 1'b0, 17);
    run_op("bcd_0",      BCD,  16'd0,    16'h0000, 32'h0000_0000, 1'b0, 17);

    // A DIV request while MUL 2*3 is busy must be dropped, and the MUL unaffected.
    issue(MUL, 16'd2, 16'd3, k);
    sb_q.push_back('{res: 32'd6, err: 1'b0, cyc: k + 17});
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.operation = DIV;
    bus.operand_a = 16'd1000;
    bus.operand_b = 16'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("busy_ignore", busy_cnt);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("busy_ignore_extra_done", 64'(dones), 64'd0);

    // start held high: back-to-back acceptances every L+1 = 18 cycles.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.operation = MUL;
    bus.operand_a = 16'd3;
    bus.operand_b = 16'd4;
    @(posedge clk);
    #1;
    k = cyc;
    sb_q.push_back('{res: 32'd12, err: 1'b0, cyc: k + 17});
    sb_q.push_back('{res: 32'd12, err: 1'b0, cyc: k + 35});
    repeat (18) @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    check("hold_start_drained", 64'(sb_q.size()), 64'd0);

    // Reset in the middle of a MUL: outputs clear at once, no done afterwards.
    issue(MUL, 16'd2, 16'd3, k);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_result", 64'(bus.result), 64'd0);
    check("midreset_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("midreset_no_done", 64'(dones), 64'd0);
    check("midreset_idle", 64'(bus.busy), 64'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
